// File: rtl/sar_avg_fifo_pkg.sv
// sar_avg_fifo_pkg: averaging FSM encoding and default sizes shared with the converter
package sar_avg_fifo_pkg;
  typedef enum logic {IDLE, ACCUM} avg_state_t;
  localparam int DEF_N = 10;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/sar_avg_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO only lands when a pop frees the slot on the same edge
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop, do_push;
  always_comb begin
    empty = level == '0;
    full = level == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rd];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      level <= (do_push && !do_pop) ? level + 1'b1 : (do_pop && !do_push) ? level - 1'b1 : level;
    end
  end
endmodule

// File: rtl/sar_avg_fifo.sv
// sar_avg_fifo: averages 2^LOG2_AVG converter samples per window and queues results with alarm and overrun flags
module sar_avg_fifo
  import sar_avg_fifo_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int LOG2_AVG = 2,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    eoc,
  input  logic [N-1:0]            din,
  input  logic [N-1:0]            thresh,
  output logic [N-1:0]            avg_data,
  output logic                    avg_valid,
  input  logic                    avg_ready,
  output logic                    alarm,
  output logic                    overrun,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = N + LOG2_AVG;
  localparam int CW = LOG2_AVG + 1;
  avg_state_t state;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [N-1:0] avg;
  logic take, last, push, full, empty;
  always_comb begin
    take = eoc && enable && !clear;
    last = cnt == CW'((1 << LOG2_AVG) - 1);
    sum = acc + AW'(din);
    avg = N'(sum >> LOG2_AVG);
    push = take && last;
    avg_valid = !empty;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      alarm <= 1'b0;
      overrun <= 1'b0;
    end else begin
      alarm <= push && (avg > thresh);
      if (clear) begin
        state <= IDLE;
        acc <= '0;
        cnt <= '0;
        overrun <= 1'b0;
      end else if (take) begin
        state <= last ? IDLE : ACCUM;
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + 1'b1;
        overrun <= overrun || (last && full && !(avg_valid && avg_ready));
      end
    end
  end
  sync_fifo #(.WIDTH(N), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(avg_ready),
    .din(avg),
    .dout(avg_data),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule

// File: doc/sar_avg_fifo.md
SAR_AVG_FIFO -- requirements
Module: sar_avg_fifo

Interface
REQ-001 Parameter N, default 10, sample width; matches converter dout width.
REQ-002 Parameter LOG2_AVG, default 2, log2 of samples per averaging window (window W = 2^LOG2_AVG, 0..6).
REQ-003 Parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = accept samples; 0 = ignore eoc.
REQ-007 clear  input  1  synchronous window restart and overrun clear.
REQ-008 eoc  input  1  converter end-of-conversion pulse; qualifies din.
REQ-009 din  input  N  converter result code.
REQ-010 thresh  input  N  alarm threshold code.
REQ-011 avg_data  output  N  FIFO head: window average.
REQ-012 avg_valid  output  1  FIFO non-empty.
REQ-013 avg_ready  input  1  consumer accepts head when avg_valid & avg_ready.
REQ-014 alarm  output  1  one-cycle pulse when a pushed average > thresh.
REQ-015 overrun  output  1  sticky: a completed window was dropped.
REQ-016 level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Sample accepted on an edge where eoc & enable & !clear; every such cycle counts, including back-to-back eoc.
REQ-018 FSM states: IDLE (no sample in window), ACCUM (1..W-1 samples held); IDLE->ACCUM on first accepted sample when W>1; ACCUM->IDLE on W-th accepted sample; clear or reset forces IDLE.
REQ-019 Accumulator width N+LOG2_AVG, unsigned, never overflows; sample counter width LOG2_AVG+1.
REQ-020 Average = (acc + din) >> LOG2_AVG on the W-th sample, truncating; W=1 passes din through, FSM stays IDLE.
REQ-021 Average pushed into FIFO on the same edge the W-th sample is accepted; avg_valid high the following cycle (latency 1 cycle from last eoc edge).
REQ-022 Accumulator and counter reset to 0 on window completion; next accepted sample starts a new window with no gap.
REQ-023 Pop on edge where avg_valid & avg_ready; avg_data shows next entry the following cycle; avg_data holds value while avg_valid & !avg_ready.
REQ-024 Full FIFO with simultaneous pop and push: both occur, level unchanged.
REQ-025 Full FIFO with push and no pop: result dropped, overrun set, FIFO contents unchanged; window still restarts.
REQ-026 Empty FIFO: avg_valid=0, avg_ready ignored, level stays 0.
REQ-027 alarm asserted for exactly the push edge's following cycle when average > thresh, also for dropped results; equal does not alarm.
REQ-028 clear: discards partial window, clears overrun; FIFO contents and handshake unaffected; an eoc coincident with clear is discarded.
REQ-029 enable low mid-window freezes accumulator and counter; window resumes when enable returns.
REQ-030 Read/write pointers wrap modulo DEPTH; level = 0..DEPTH.

Reset
REQ-031 On reset: FSM=IDLE, acc=0, count=0, pointers=0, level=0, avg_valid=0, avg_data=0, alarm=0, overrun=0.
REQ-032 Reset mid-window or with FIFO non-empty discards all data; reset dominates clear, eoc and avg_ready.

Structure
REQ-033 Shared package holds FSM state encoding (IDLE, ACCUM) and default N/DEPTH constants, common with the converter.
REQ-034 One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), instantiated once; averaging FSM in the top.

Verification
REQ-035 W=4, din 100,200,300,401 on eoc pulses -> avg_data=250 (truncated), avg_valid 1 cycle after 4th eoc, level=1.
REQ-036 avg_ready=0, 5 windows of constant 512 -> level=4, 5th dropped, overrun=1; clear -> overrun=0, level=4.
REQ-037 Full FIFO, 4th eoc coincident with avg_ready=1 -> pop and push same edge, level stays 4, overrun=0.
REQ-038 thresh=500, windows averaging 500 then 501 -> no alarm then one single-cycle alarm.
REQ-039 2 samples taken, then clear, then 4 samples of 8 -> avg_data=8 (partial window discarded).
REQ-040 Reset asserted with level=3 mid-window -> next cycle level=0, avg_valid=0, all outputs 0; eoc during reset ignored.
